// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types for the HI/LO divider sequencer: FSM state encoding and
// the latched operand bundle.
package hilo_div_ctrl_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } div_state_e;

    typedef struct packed {
        logic             is_signed;
        logic [DIV_W-1:0] src1;
        logic [DIV_W-1:0] src2;
    } div_req_t;

    function automatic logic [DIV_W-1:0] dout_quotient(input logic [2*DIV_W-1:0] d);
        return d[2*DIV_W-1:DIV_W];
    endfunction

    function automatic logic [DIV_W-1:0] dout_remainder(input logic [2*DIV_W-1:0] d);
        return d[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/hilo_div_ctrl_axis_hold_src.sv
// One AXI-Stream source slot: raises tvalid on start, holds it until the
// handshake, then remembers that the beat was accepted until cleared.
module axis_hold_src (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic clear,
    input  logic tready,
    output logic tvalid,
    output logic accepted
);

    logic r_tvalid;
    logic r_accepted;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tvalid   <= 1'b0;
            r_accepted <= 1'b0;
        end else if (clear) begin
            r_tvalid   <= 1'b0;
            r_accepted <= 1'b0;
        end else if (start) begin
            r_tvalid   <= 1'b1;
            r_accepted <= 1'b0;
        end else if (r_tvalid && tready) begin
            r_tvalid   <= 1'b0;
            r_accepted <= 1'b1;
        end
    end

    assign tvalid   = r_tvalid;
    assign accepted = r_accepted;

endmodule

// File: rtl/hilo_div_ctrl.sv
// EXE-stage divider sequencer: issues operands to the div/divu cores,
// stalls EXE until the result returns, and drops results of flushed ops.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        stall,
    output logic        res_valid,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_signed,
    output logic        dvd_tvalid,
    input  logic        dvd_tready,
    output logic [31:0] dvd_tdata,
    output logic        dvs_tvalid,
    input  logic        dvs_tready,
    output logic [31:0] dvs_tdata,
    input  logic        dout_tvalid,
    input  logic [63:0] dout_tdata
);

    div_state_e  r_state;
    div_req_t    r_req;
    logic        r_cancel;
    logic        r_res_valid;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic w_start;
    logic w_issue_done;
    logic w_dvd_acc;
    logic w_dvs_acc;
    logic w_dvd_done;
    logic w_dvs_done;

    assign w_start      = (r_state == IDLE) && req_valid && !flush;
    // A channel counts as done in the same cycle its handshake fires.
    assign w_dvd_done   = w_dvd_acc || (dvd_tvalid && dvd_tready);
    assign w_dvs_done   = w_dvs_acc || (dvs_tvalid && dvs_tready);
    assign w_issue_done = (r_state == ISSUE) && w_dvd_done && w_dvs_done;

    axis_hold_src u_dvd_src (
        .clk      (clk),
        .resetn   (resetn),
        .start    (w_start),
        .clear    (w_issue_done),
        .tready   (dvd_tready),
        .tvalid   (dvd_tvalid),
        .accepted (w_dvd_acc)
    );

    axis_hold_src u_dvs_src (
        .clk      (clk),
        .resetn   (resetn),
        .start    (w_start),
        .clear    (w_issue_done),
        .tready   (dvs_tready),
        .tvalid   (dvs_tvalid),
        .accepted (w_dvs_acc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_cancel    <= 1'b0;
            r_res_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req.is_signed <= req_signed;
                        r_req.src1      <= req_src1;
                        r_req.src2      <= req_src2;
                        r_cancel        <= 1'b0;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Operands already offered must still be delivered; a flush
                    // only decides whether the eventual result is kept.
                    if (w_issue_done) begin
                        r_state  <= (r_cancel || flush) ? DRAIN : WAIT;
                        r_cancel <= 1'b0;
                    end else if (flush) begin
                        r_cancel <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dout_tvalid) begin
                        if (flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_hi        <= dout_remainder(dout_tdata);
                            r_lo        <= dout_quotient(dout_tdata);
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else if (flush) begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                DRAIN: begin
                    if (dout_tvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall      = resetn && req_valid && !flush && (r_state != DONE);
    assign res_valid  = r_res_valid;
    assign hi_we      = r_res_valid && !flush;
    assign lo_we      = r_res_valid && !flush;
    assign hi_wdata   = r_hi;
    assign lo_wdata   = r_lo;
    assign div_signed = r_req.is_signed;
    assign dvd_tdata  = r_req.src1;
    assign dvs_tdata  = r_req.src2;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomised scoreboard bench for hilo_div_ctrl with a behavioural divider
// core model and an independent latency/handshake reference.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_signed, flush;
    logic [31:0] req_src1, req_src2;
    logic        stall, res_valid, hi_we, lo_we, div_signed;
    logic [31:0] hi_wdata, lo_wdata;
    logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready;
    logic [31:0] dvd_tdata, dvs_tdata;
    logic        dout_tvalid;
    logic [63:0] dout_tdata;

    hilo_div_ctrl dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_signed(req_signed),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush), .stall(stall),
        .res_valid(res_valid), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata), .div_signed(div_signed),
        .dvd_tvalid(dvd_tvalid), .dvd_tready(dvd_tready), .dvd_tdata(dvd_tdata),
        .dvs_tvalid(dvs_tvalid), .dvs_tready(dvs_tready), .dvs_tdata(dvs_tdata),
        .dout_tvalid(dout_tvalid), .dout_tdata(dout_tdata)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb_q[$];
    int          n_writes = 0, n_dvd_v = 0, n_dvs_v = 0;
    logic [31:0] last_lo, last_hi;
    int          rel = 0, dly_a = 0, dly_b = 0, core_lat = 1;
    bit          sg_watch = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Divider IP behaviour: {quotient, remainder}; zero divisor and signed
    // overflow produce fixed patterns that the sequencer must pass through.
    function automatic logic [63:0] core_div(input logic [31:0] a, input logic [31:0] b, input bit sg);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return {q, r};
    endfunction

    // Core model: accepts both operand beats, answers core_lat cycles later.
    logic [31:0] c_a, c_b;
    bit          c_sg, got_a, got_b, c_load;
    int          c_cnt = 0, c_lat_l = 1;
    logic [63:0] c_res;
    always @(posedge clk) begin
        c_load = 0;
        if (!resetn) begin
            got_a = 0; got_b = 0;
        end else begin
            if (dvd_tvalid && dvd_tready) begin c_a = dvd_tdata; c_sg = div_signed; got_a = 1; end
            if (dvs_tvalid && dvs_tready) begin c_b = dvs_tdata; got_b = 1; end
            if (got_a && got_b) begin
                got_a = 0; got_b = 0; c_load = 1;
                c_res = core_div(c_a, c_b, c_sg); c_lat_l = core_lat;
            end
        end
        #1;
        dout_tvalid = 1'b0;
        dout_tdata  = {$urandom, $urandom};
        if (!resetn) c_cnt = 0;
        else if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin dout_tvalid = 1'b1; dout_tdata = c_res; end
        end
        if (c_load) c_cnt = c_lat_l;
    end

    // Monitor: scoreboard pops on every HI/LO write; AXI hold rule per channel.
    bit          pv_a, pf_a, pv_b, pf_b;
    logic [31:0] pd_a, pd_b;
    logic [63:0] m_exp;
    always @(negedge clk) begin
        if (!resetn) begin
            pv_a = 0; pv_b = 0;
        end else begin
            if (hi_we || lo_we) begin
                n_writes++;
                chk("we_pair", 64'(hi_we), 64'(lo_we));
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got lo=%0h hi=%0h expected no write", lo_wdata, hi_wdata);
                end else begin
                    m_exp = sb_q.pop_front();
                    chk("lo_wdata", 64'(lo_wdata), 64'(m_exp[63:32]));
                    chk("hi_wdata", 64'(hi_wdata), 64'(m_exp[31:0]));
                end
                last_lo = lo_wdata; last_hi = hi_wdata;
            end
            if (pv_a && !pf_a) chk("dvd_hold", {31'd0, dvd_tvalid, dvd_tdata}, {31'd0, 1'b1, pd_a});
            if (pv_b && !pf_b) chk("dvs_hold", {31'd0, dvs_tvalid, dvs_tdata}, {31'd0, 1'b1, pd_b});
            pv_a = dvd_tvalid; pf_a = dvd_tvalid && dvd_tready; pd_a = dvd_tdata;
            pv_b = dvs_tvalid; pf_b = dvs_tvalid && dvs_tready; pd_b = dvs_tdata;
            if (dvd_tvalid) n_dvd_v++;
            if (dvs_tvalid) n_dvs_v++;
        end
    end

    task automatic set_ready();
        dvd_tready = (rel >= 1 + dly_a);
        dvs_tready = (rel >= 1 + dly_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; rel++; set_ready();
        end
    endtask

    // One EXE-stage divide; entered and left at 1 time unit after a rising edge.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                          input int lat, input int da, input int db, input int fl_at,
                          input bit chk_lat, output int st, output bit flushed);
        bit done;
        int dmax;
        core_lat = lat; dly_a = da; dly_b = db; rel = 0; set_ready();
        req_valid = 1'b1; req_signed = sg; req_src1 = a; req_src2 = b;
        sb_q.push_back(core_div(a, b, sg));
        st = 0; done = 0; flushed = 0;
        dmax = (da > db) ? da : db;
        for (int t = 0; t < 200 && !done; t++) begin
            flush = (t == fl_at);
            if (flush) begin
                flushed = 1;
                if (sb_q.size() > 0) void'(sb_q.pop_back());
            end
            @(negedge clk);
            if (sg_watch && t >= 1 && !flush) chk("div_signed", 64'(div_signed), 64'(sg));
            if (flush) done = 1;
            else if (stall) st++;
            else begin
                done = 1;
                chk("done_strobe", {61'd0, res_valid, hi_we, lo_we}, 64'd7);
            end
            @(posedge clk); #1; rel++; set_ready();
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: got stall still high expected completion within 200 cycles");
        end
        req_valid = 1'b0; flush = 1'b0;
        if (chk_lat && !flushed) chk("latency", 64'(st), 64'(3 + lat + dmax));
    endtask

    int          st, w0, a0, b0;
    bit          fl, skip_lat;
    logic [31:0] ra, rb;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; dvd_tready = 1'b0; dvs_tready = 1'b0;
        dout_tvalid = 1'b0; dout_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {53'd0, stall, dvd_tvalid, dvs_tvalid, res_valid, hi_we, lo_we,
                              div_signed, (hi_wdata | lo_wdata | dvd_tdata | dvs_tdata) != 0, 3'd0}, 64'd0);
        req_valid = 1'b1; #1;
        chk("reset_stall", 64'(stall), 64'd0);
        req_valid = 1'b0; #2 resetn = 1'b1;
        @(posedge clk); #1;

        // DIVU 100/7, ready immediately, core latency 4
        w0 = n_writes;
        do_div(32'd100, 32'd7, 1'b0, 4, 0, 0, -1, 1'b0, st, fl);
        idle(2);
        chk("divu_stall_cycles", 64'(st), 64'd7);
        chk("divu_one_write", 64'(n_writes - w0), 64'd1);
        chk("divu_lo", 64'(last_lo), 64'd14);
        chk("divu_hi", 64'(last_hi), 64'd2);

        // DIV -7/2
        sg_watch = 1;
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 3, 0, 0, -1, 1'b1, st, fl);
        sg_watch = 0;
        idle(1);
        chk("div_lo", 64'(last_lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", 64'(last_hi), 64'h0000_0000_FFFF_FFFF);

        // Skewed ready: dividend 3 cycles late, divisor immediate
        a0 = n_dvd_v; b0 = n_dvs_v;
        do_div(32'd1000, 32'd9, 1'b0, 2, 3, 0, -1, 1'b1, st, fl);
        chk("skew_dvd_valid_cycles", 64'(n_dvd_v - a0), 64'd4);
        chk("skew_dvs_valid_cycles", 64'(n_dvs_v - b0), 64'd1);
        idle(1);

        // Flush in WAIT, then a DIVU issued during DRAIN
        w0 = n_writes;
        do_div(32'd5000, 32'd3, 1'b0, 6, 0, 0, 4, 1'b0, st, fl);
        do_div(32'd77, 32'd5, 1'b0, 2, 0, 0, -1, 1'b0, st, fl);
        idle(2);
        chk("drain_stall_cycles", 64'(st), 64'd9);
        chk("drain_writes", 64'(n_writes - w0), 64'd1);
        chk("drain_lo", 64'(last_lo), 64'd15);
        chk("drain_hi", 64'(last_hi), 64'd2);

        // Flush during ISSUE with both channels not ready for 5 cycles
        w0 = n_writes; a0 = n_dvd_v; b0 = n_dvs_v;
        do_div(32'd123, 32'd4, 1'b1, 2, 5, 5, 2, 1'b0, st, fl);
        idle(12);
        chk("issue_flush_dvd_cycles", 64'(n_dvd_v - a0), 64'd6);
        chk("issue_flush_dvs_cycles", 64'(n_dvs_v - b0), 64'd6);
        chk("issue_flush_writes", 64'(n_writes - w0), 64'd0);

        // Asynchronous reset in the middle of WAIT
        core_lat = 5; dly_a = 0; dly_b = 0; rel = 0; set_ready();
        req_valid = 1'b1; req_signed = 1'b1; req_src1 = 32'd1000; req_src2 = 32'd3;
        idle(3);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_outputs", {53'd0, stall, dvd_tvalid, dvs_tvalid, res_valid, hi_we, lo_we,
                                    div_signed, (hi_wdata | lo_wdata | dvd_tdata | dvs_tdata) != 0, 3'd0}, 64'd0);
        req_valid = 1'b0;
        @(posedge clk); #3 resetn = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Randomised traffic with occasional flushes
        skip_lat = 0;
        for (int k = 0; k < 40; k++) begin
            int lat, da, db, fat;
            bit sg;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb = $urandom_range(1, 50);
            if ($urandom_range(0, 9) == 0) rb = 32'd0;
            sg  = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 6);
            da  = $urandom_range(0, 3);
            db  = $urandom_range(0, 3);
            fat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3 + lat + 3) : -1;
            do_div(ra, rb, sg, lat, da, db, fat, !skip_lat, st, fl);
            skip_lat = fl;
            idle($urandom_range(0, 2));
        end
        idle(15);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
